// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared constants for the ALU arbiter slice
// Purpose: ALU op encodings, requester ids and datapath width used by
//          alu_arbiter and rr_arb2.
// Ports:   none (package).
package alu_arb_pkg;

  localparam int ALU_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with priority pointer
// Purpose: grants one of two requesters per cycle when enabled; on a tie the
//          pointer decides, and after any grant the pointer moves to the
//          requester that was not granted.
// Ports:   clk, reset_n (async, active-low)
//          req[1:0]   request vector, bit N = requester N
//          enable     grants allowed this cycle
//          init_ptr   pointer value loaded by reset
//          grant[1:0] one-hot grant (all zero when no grant)
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       init_ptr,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ptr_q == REQ0) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    // Pointer hands priority to whoever lost (or was idle) this cycle.
    if (grant[0]) begin
      ptr_d = REQ1;
    end else if (grant[1]) begin
      ptr_d = REQ0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= init_ptr;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one 16-bit ALU between two requesters
// Purpose: round-robin selects a requester, drives the external ALU with its
//          op/operands, registers the ALU result and returns it on a
//          valid/ready response channel tagged with the requester id.
// Ports:   clk, reset_n (async, active-low)
//          req0_*/req1_*  valid/ready request channels with op, a, b
//          alu_op, alu_i0, alu_i1 -> ALU inputs; alu_o, alu_cout <- ALU
//          rsp_valid/rsp_ready response handshake; rsp_id, rsp_data,
//          rsp_cout, rsp_zero response fields
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W       = ALU_W,
  parameter int RR_INIT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_i0,
  output logic [W-1:0] alu_i1,
  input  logic [W-1:0] alu_o,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_cout,
  output logic         rsp_zero
);

  localparam logic RR_INIT_BIT = 1'(RR_INIT);

  logic [1:0]   grant;
  logic         slot_free;

  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q,    rsp_id_d;
  logic [W-1:0] rsp_data_q,  rsp_data_d;
  logic         rsp_cout_q,  rsp_cout_d;
  logic         rsp_zero_q,  rsp_zero_d;

  // Slot is free when empty or being drained this same cycle, which keeps
  // back-to-back issue at one result per clock.
  assign slot_free = !rsp_valid_q || rsp_ready;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      ({req1_valid, req0_valid}),
    .enable   (slot_free),
    .init_ptr (RR_INIT_BIT),
    .grant    (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_op = 2'b00;
    alu_i0 = '0;
    alu_i1 = '0;
    if (grant[0]) begin
      alu_op = req0_op;
      alu_i0 = req0_a;
      alu_i1 = req0_b;
    end else if (grant[1]) begin
      alu_op = req1_op;
      alu_i0 = req1_a;
      alu_i1 = req1_b;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_zero_d  = rsp_zero_q;
    if (|grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant[1] ? REQ1 : REQ0;
      rsp_data_d  = alu_o;
      // Carry only has meaning for add/sub (op[1]==0); logic ops report 0.
      rsp_cout_d  = alu_cout & ~alu_op[1];
      rsp_zero_d  = (alu_o == '0);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_i0, alu_i1, alu_o;
  logic        alu_cout;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
  logic [15:0] rsp_data;
  logic [16:0] alu_sum;

  always #5 clk = ~clk;

  alu_arbiter #(.W(16), .RR_INIT(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
  );

  // External ALU stand-in; drives carry high on logic ops so masking shows.
  always_comb begin
    alu_sum = '0;
    case (alu_op)
      OP_ADD:  alu_sum = {1'b0, alu_i0} + {1'b0, alu_i1};
      OP_SUB:  alu_sum = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
      OP_AND:  alu_sum = {1'b1, alu_i0 & alu_i1};
      default: alu_sum = {1'b1, alu_i0 | alu_i1};
    endcase
  end
  assign alu_o    = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        cout;
    logic        zero;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_valid = 1'b0;
  logic m_ptr = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {cout, data}
  function automatic logic [16:0] exp_result(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a >= b), 16'(a - b)};
      OP_AND:  r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  // Arbitration model + scoreboard, sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic        g0, g1, free;
    logic [16:0] x;
    rsp_t        e;
    if (!reset_n) begin
      m_valid = 1'b0;
      m_ptr   = 1'b0;
      sb.delete();
    end else begin
      free = !m_valid || rsp_ready;
      g0 = free && req0_valid && (!req1_valid || m_ptr == REQ0);
      g1 = free && req1_valid && (!req0_valid || m_ptr == REQ1);
      check_val("req0_ready", req0_ready, g0);
      check_val("req1_ready", req1_ready, g1);
      check_val("rsp_valid", rsp_valid, m_valid);
      if (!g0 && !g1) begin
        check_val("alu_op_idle", alu_op, 0);
        check_val("alu_i0_idle", alu_i0, 0);
        check_val("alu_i1_idle", alu_i1, 0);
      end
      if (m_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check_val("sb_empty", 0, 1);
        end else begin
          e = sb.pop_front();
          check_val("sb_id", rsp_id, e.id);
          check_val("sb_data", rsp_data, e.data);
          check_val("sb_cout", rsp_cout, e.cout);
          check_val("sb_zero", rsp_zero, e.zero);
        end
      end
      if (g0 || g1) begin
        x = g0 ? exp_result(req0_op, req0_a, req0_b) : exp_result(req1_op, req1_a, req1_b);
        sb.push_back('{id: g1, data: x[15:0], cout: x[16], zero: (x[15:0] == 16'h0)});
        m_valid = 1'b1;
        m_ptr   = g0 ? REQ1 : REQ0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic issue(input logic id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic ec, input logic ez);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
    end
    check_val("issue_accept", ok, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_val("dir_valid", rsp_valid, 1);
    check_val("dir_id", rsp_id, id);
    check_val("dir_data", rsp_data, ed);
    check_val("dir_cout", rsp_cout, ec);
    check_val("dir_zero", rsp_zero, ez);
  endtask

  initial begin
    logic [15:0] held;
    logic        ok;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'd1; req0_b = 16'd2;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 16'd9; req1_b = 16'd4;
    #1;
    check_val("rst_valid", rsp_valid, 0);
    check_val("rst_id", rsp_id, 0);
    check_val("rst_data", rsp_data, 0);
    check_val("rst_cout", rsp_cout, 0);
    check_val("rst_zero", rsp_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Both valid, sink always ready: strict alternation starting at req0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("alt_g0", req0_ready, (i % 2) == 0);
      check_val("alt_g1", req1_ready, (i % 2) == 1);
      if (i > 0) check_val("alt_valid", rsp_valid, 1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    issue(1'b0, OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    issue(1'b1, OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    issue(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    issue(1'b0, OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);
    issue(1'b0, OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0);

    // Backpressure: fill the slot from req0, then stall with both valid.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h1234; req0_b = 16'h0001;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req0_ready;
    end
    check_val("bp_fill", ok, 1);
    @(posedge clk); #1;
    req0_op = OP_AND; req0_a = 16'h00FF; req0_b = 16'h0F0F;
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 16'h1000; req1_b = 16'h0001;
    held = 16'h1235;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_r0", req0_ready, 0);
      check_val("bp_r1", req1_ready, 0);
      check_val("bp_valid", rsp_valid, 1);
      check_val("bp_data", rsp_data, held);
      check_val("bp_id", rsp_id, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("bp_resume_r1", req1_ready, 1);
    check_val("bp_resume_r0", req0_ready, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check_val("bp_next_r0", req0_ready, 1);

    // Hold req0's result (pointer now favours req1), then reset mid-flight.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check_val("pre_rst_valid", rsp_valid, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_val("async_valid", rsp_valid, 0);
    check_val("async_data", rsp_data, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("no_stale", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h0010; req0_b = 16'h0020;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 16'h0030; req1_b = 16'h0040;
    @(negedge clk);
    check_val("ptr_init_r0", req0_ready, 1);
    check_val("ptr_init_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU datapath between two requesters, e.g. the register-transfer sequencer and the test/debug port.
- Per-cycle 2-way round-robin arbitration; drives the ALU's op and operand inputs from the winner.
- Captures the combinational ALU result in an output register and returns it through a valid/ready response channel, tagged with the requester id.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged and instantiated outside this block.

Parameters:
- W, 16, datapath width; only 16 is supported (matches the ALU).
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  2  00 add, 01 sub, 10 and, 11 or
- req0_a  input  W  operand A
- req0_b  input  W  operand B
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0
- alu_op  output  2  to ALU op
- alu_i0  output  W  to ALU i0
- alu_i1  output  W  to ALU i1
- alu_o  input  W  from ALU result
- alu_cout  input  1  from ALU carry-out
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester that issued the result
- rsp_data  output  W  result
- rsp_cout  output  1  carry/no-borrow for add/sub; 0 for and/or
- rsp_zero  output  1  rsp_data == 0

Behaviour:
- Reset (asynchronous, reset_n low): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cout=0, rsp_zero=0, priority pointer=RR_INIT. Reset mid-operation discards any held result; no response is emitted for it.
- Issue slot free when rsp_valid==0, or when rsp_valid && rsp_ready in the same cycle (drain and refill, full throughput).
- Grant, combinational, only when the slot is free:
  - Exactly one valid: grant it.
  - Both valid: grant the requester named by the priority pointer.
  - No grant: both reqN_ready=0.
- reqN_ready = grantN. The handshake completes on reqN_valid && reqN_ready. Requesters hold op/a/b stable until accepted.
- Priority pointer: after any grant, it points to the requester not granted. With no grant it is unchanged.
- ALU drive:
  - Granted: alu_op/alu_i0/alu_i1 = granted request's op/a/b, combinationally.
  - No grant: all zero.
- Capture on the grant cycle edge:
  - rsp_data = alu_o; rsp_id = granted id; rsp_zero = (alu_o == 0).
  - rsp_cout = alu_cout if op[1]==0, else 0.
  - rsp_valid = 1.
- Latency: accepted at edge N → rsp_valid visible after edge N, held until the rsp_ready handshake.
- Response clear: rsp_valid && rsp_ready with no new grant → rsp_valid=0 next cycle. The data fields keep their last value.
- Backpressure: while rsp_valid && !rsp_ready, no grants. Response fields are stable and the pointer is frozen.
- Subtraction semantics: A-B = A + ~B + 1, so cout=1 means no borrow (A ≥ B, unsigned).
- reqN_ready never depends on rsp_data. rsp_ready → reqN_ready is a combinational path by design.

Decomposition:
- Shared package alu_arb_pkg:
  - op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - requester id constants REQ0=1'b0, REQ1=1'b1
  - width constant ALU_W=16
- One sub-module: rr_arb2
  - Inputs: clk, reset_n, req[1:0], enable, init value.
  - Outputs: one-hot grant[1:0].
  - Contains the priority pointer.
- alu_arbiter contains the operand mux and the response register.

Test Plan:
- Reset with both valid, RR_INIT=0 → after reset_n rises, req0 is granted first. Then the bench holds both valid and rsp_ready=1; grants alternate 0,1,0,1, with rsp_valid high every cycle.
- req0 SUB a=0x0005 b=0x0003 → next cycle rsp_data=0x0002, rsp_cout=1, rsp_id=0, rsp_zero=0.
- req1 SUB a=0x0003 b=0x0005 → rsp_data=0xFFFE, rsp_cout=0. Then req1 ADD 0xFFFF+0x0001 → rsp_data=0x0000, rsp_cout=1, rsp_zero=1.
- req0 AND 0xF0F0,0x0FF0 → rsp_data=0x00F0, rsp_cout=0. Then req0 OR 0xF0F0,0x0FF0 → rsp_data=0xFFF0, rsp_cout=0.
- Backpressure: rsp_ready=0 for 3 cycles with both valid → req0_ready=req1_ready=0, response stable for 3 cycles. Raise rsp_ready → the next grant goes to the requester not last served, in the same cycle.
- reset_n pulsed low while rsp_valid=1 → rsp_valid=0 immediately (asynchronous), pointer=RR_INIT, and no stale response after release.
